// File: rtl/tff_pkg.sv
// Shared definitions for the toggle-cell counter: mode field width and encodings.
package tff_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD   = 3'b000;
    localparam logic [MODE_W-1:0] MODE_UP     = 3'b001;
    localparam logic [MODE_W-1:0] MODE_DOWN   = 3'b010;
    localparam logic [MODE_W-1:0] MODE_LOAD   = 3'b011;
    localparam logic [MODE_W-1:0] MODE_TOGGLE = 3'b100;
    localparam logic [MODE_W-1:0] MODE_CLEAR  = 3'b101;

endpackage

// File: rtl/tff_counter_t_cell.sv
// Single-bit toggle flip-flop with enable and synchronous active-high reset.
module t_cell #(
    parameter bit RST_BIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic t_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    assign q_d = q_q ^ (en_i & t_i);

    // Flip the stored bit when enabled and asked to toggle; reset forces RST_BIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= RST_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tff_counter.sv
// Multi-mode counter/register built from a row of toggle cells.
// The next value is computed as a whole word; each cell is told to toggle
// wherever the current and next values differ.
module tff_counter
    import tff_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 2 ** WIDTH,
    parameter bit SATURATE = 1'b0,
    parameter int RST_VAL  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  t_mask,
    input  logic [WIDTH-1:0]  load_val,
    input  logic              clr_ovf,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  qn,
    output logic              tc,
    output logic              ovf
);

    // Range limits held one bit wider so MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RST_VAL);

    if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH)) || (RST_VAL < 0) || (RST_VAL >= MODULUS)) begin : g_param_check
        $error("tff_counter: illegal MODULUS/RST_VAL for the chosen WIDTH");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] next_d;
    logic [WIDTH-1:0] tog_val;
    logic [WIDTH:0]   cnt_x;
    logic             range_evt;
    logic             set_ovf;
    logic             tc_q;
    logic             tc_d;
    logic             ovf_q;
    logic             ovf_d;

    assign cnt_x   = {1'b0, cnt_q};
    assign tog_val = cnt_q ^ t_mask;

    // Next-value selection. Increments/decrements are only taken away from the
    // range ends, so the WIDTH-bit add/subtract can never overflow.
    always_comb begin
        next_d    = cnt_q;
        range_evt = 1'b0;
        set_ovf   = 1'b0;
        if (en) begin
            case (mode)
                MODE_UP: begin
                    if (cnt_x == MAX_X) begin
                        range_evt = 1'b1;
                        next_d    = SATURATE ? MAX_V : '0;
                    end else begin
                        next_d = cnt_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (cnt_q == '0) begin
                        range_evt = 1'b1;
                        next_d    = SATURATE ? '0 : MAX_V;
                    end else begin
                        next_d = cnt_q - WIDTH'(1);
                    end
                end
                MODE_LOAD: begin
                    if ({1'b0, load_val} >= MOD_X) begin
                        next_d  = MAX_V;
                        set_ovf = 1'b1;
                    end else begin
                        next_d = load_val;
                    end
                end
                MODE_TOGGLE: begin
                    if ({1'b0, tog_val} >= MOD_X) begin
                        next_d  = MAX_V;
                        set_ovf = 1'b1;
                    end else begin
                        next_d = tog_val;
                    end
                end
                MODE_CLEAR: begin
                    next_d = '0;
                end
                default: begin
                    next_d = cnt_q;
                end
            endcase
        end
    end

    assign tc_d = range_evt;

    // Sticky flag: a new set wins over a clear, clear wins over hold.
    always_comb begin
        if (range_evt || set_ovf) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Register the terminal-count pulse and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_cell #(
            .RST_BIT (RST_VEC[i])
        ) u_cell (
            .clk_i (clk),
            .rst_i (rst),
            .en_i  (en),
            .t_i   (cnt_q[i] ^ next_d[i]),
            .q_o   (cnt_q[i])
        );
    end

    assign q   = cnt_q;
    assign qn  = ~cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_tff_counter.sv
// Directed bench for tff_counter: a wrapping and a saturating instance
// (WIDTH=4, MODULUS=10, RST_VAL=5) share one set of inputs.
module tb_tff_counter;
    import tff_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [MODE_W-1:0] mode;
    logic [3:0]       t_mask;
    logic [3:0]       load_val;
    logic             clr_ovf;

    logic [3:0] q_w, qn_w, q_s, qn_s;
    logic       tc_w, ovf_w, tc_s, ovf_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RST_VAL(5)) dut_w (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t_mask(t_mask),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q_w), .qn(qn_w), .tc(tc_w), .ovf(ovf_w)
    );

    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RST_VAL(5)) dut_s (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t_mask(t_mask),
        .load_val(load_val), .clr_ovf(clr_ovf),
        .q(q_s), .qn(qn_s), .tc(tc_s), .ovf(ovf_s)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_HOLD;
        t_mask = 4'd0; load_val = 4'd0; clr_ovf = 1'b0;
        #2;
        step(); step();
        chk("rst_q",   32'(q_w),   5);
        chk("rst_qn",  32'(qn_w),  10);
        chk("rst_tc",  32'(tc_w),  0);
        chk("rst_ovf", 32'(ovf_w), 0);
        chk("rst_q_s", 32'(q_s),   5);

        // Disabled with UP selected: full hold
        rst = 1'b0; en = 1'b0; mode = MODE_UP;
        step(); step(); step();
        chk("hold_q",  32'(q_w),  5);
        chk("hold_tc", 32'(tc_w), 0);

        // Wrap/saturate at the top
        en = 1'b1; mode = MODE_LOAD; load_val = 4'd8;
        step();
        chk("load8_q", 32'(q_w), 8);
        mode = MODE_UP;
        step();
        chk("up9_q",   32'(q_w),   9);
        chk("up9_tc",  32'(tc_w),  0);
        chk("up9_ovf", 32'(ovf_w), 0);
        step();
        chk("wrap_q",    32'(q_w),   0);
        chk("wrap_tc",   32'(tc_w),  1);
        chk("wrap_ovf",  32'(ovf_w), 1);
        chk("sat1_q",    32'(q_s),   9);
        chk("sat1_tc",   32'(tc_s),  1);
        chk("sat1_ovf",  32'(ovf_s), 1);
        step();
        chk("sat2_q",    32'(q_s),  9);
        chk("sat2_tc",   32'(tc_s), 1);
        chk("wrap1_q",   32'(q_w),  1);
        chk("wrap1_tc",  32'(tc_w), 0);
        step();
        chk("sat3_q",    32'(q_s),  9);
        chk("sat3_tc",   32'(tc_s), 1);

        // clr_ovf acts with en=0
        en = 1'b0; clr_ovf = 1'b1;
        step();
        chk("clr_dis_ovf", 32'(ovf_w), 0);
        chk("clr_dis_tc",  32'(tc_s),  0);
        chk("clr_dis_q",   32'(q_w),   2);
        clr_ovf = 1'b0;

        // Wrap/saturate at the bottom
        en = 1'b1; mode = MODE_CLEAR;
        step();
        chk("clear_q", 32'(q_w), 0);
        mode = MODE_DOWN;
        step();
        chk("dwrap_q",   32'(q_w),   9);
        chk("dwrap_tc",  32'(tc_w),  1);
        chk("dwrap_ovf", 32'(ovf_w), 1);
        chk("dsat_q",    32'(q_s),   0);
        chk("dsat_tc",   32'(tc_s),  1);

        // Event plus clear on the same edge: the event wins (sat); no event (wrap) clears
        clr_ovf = 1'b1;
        step();
        chk("pri_set_ovf", 32'(ovf_s), 1);
        chk("pri_clr_ovf", 32'(ovf_w), 0);
        chk("pri_w_q",     32'(q_w),   8);
        mode = MODE_HOLD;
        step();
        chk("clr_only_ovf", 32'(ovf_s), 0);
        chk("hold_tc_s",    32'(tc_s),  0);
        clr_ovf = 1'b0;

        // Out-of-range load clamps
        mode = MODE_LOAD; load_val = 4'd12;
        step();
        chk("ld12_q",   32'(q_w),   9);
        chk("ld12_ovf", 32'(ovf_w), 1);
        chk("ld12_tc",  32'(tc_w),  0);
        en = 1'b0; clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0; en = 1'b1; load_val = 4'd3;
        step();
        chk("ld3_q", 32'(q_w), 3);

        // Toggle into range clamps, toggle within range, zero mask holds
        mode = MODE_TOGGLE; t_mask = 4'b1000;
        step();
        chk("tg11_q",   32'(q_w),   9);
        chk("tg11_ovf", 32'(ovf_w), 1);
        chk("tg11_tc",  32'(tc_w),  0);
        mode = MODE_LOAD;
        step();
        mode = MODE_TOGGLE; t_mask = 4'b0101;
        step();
        chk("tg6_q",  32'(q_w),  6);
        chk("tg6_qn", 32'(qn_w), 9);
        t_mask = 4'b0000;
        step();
        chk("tg0_q", 32'(q_w), 6);

        // Reset while counting
        mode = MODE_LOAD; load_val = 4'd7;
        step();
        mode = MODE_UP; rst = 1'b1;
        step();
        chk("mrst_q",   32'(q_w),   5);
        chk("mrst_tc",  32'(tc_w),  0);
        chk("mrst_ovf", 32'(ovf_w), 0);
        rst = 1'b0;
        step();
        chk("resume_q", 32'(q_w), 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
